lsu_data_mem: RTL and testbench
===============================

# lsu_data_mem

Parametrised load/store data memory with a valid/ready request/response handshake, configurable access latency and fault reporting. It is the successor to the single-cycle combinational-read data memory. It sits between the execute stage and writeback of the multi-cycle/pipelined core. It accepts RISC-V `funct3`-encoded loads and stores, applies byte lanes and sign/zero extension, and flags misaligned, out-of-range or illegal accesses instead of silently executing them.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `DEPTH_BYTES`, 4096: byte capacity. Power of two, at least 4.
- `LATENCY`, 1: cycles from request acceptance to `rsp_valid`. Must be ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access size and type. 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data. Low bytes are used per size.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out XLEN: load result after extension. 0 for stores and for faults.
- `rsp_fault` out 1: access was rejected.

## Operation
- Storage is a little-endian byte array `[0:DEPTH_BYTES-1]`. It is not cleared by `rst`.
- The FSM has three states: IDLE, WAIT and RESP.
  - IDLE: `req_ready`=1. On `req_valid`, the request is accepted and all request fields are latched. The FSM goes to RESP if `LATENCY`=1, otherwise to WAIT with `cnt`=`LATENCY`-1.
  - WAIT: `req_ready`=0. `cnt` decrements each cycle. On the cycle `cnt`=1 the FSM goes to RESP.
  - RESP: `rsp_valid`=1 and the outputs are held stable until `rsp_ready`.
    - `req_ready` = `rsp_ready`. A new request may be accepted in the same cycle the response completes (back-to-back).
    - If `rsp_ready` and `req_valid`: the new request is accepted and the FSM goes to RESP or WAIT as from IDLE.
    - If `rsp_ready` without `req_valid`: the FSM goes to IDLE.
- The memory access is performed on the clock edge that enters RESP, using the latched request.
  - A load reads the array contents as they were before that edge.
  - A store writes 1, 2 or 4 bytes at that edge.
- Fault conditions (any one sets `rsp_fault`=1, performs no write and gives `rsp_rdata`=0):
  - `funct3` is not in {000, 001, 010, 100, 101}, or a store uses 100 or 101.
  - A halfword access has `addr[0]`=1.
  - A word access has `addr[1:0]`≠0.
  - `addr` + size − 1 ≥ `DEPTH_BYTES` (range check is on the full XLEN address).
- Load extension:
  - lb: sign-extend bit 7.
  - lh: sign-extend bit 15.
  - lbu / lhu: zero-extend.
  - lw: the word as stored.

## Timing
- Reset values: `req_ready`=0 while `rst` is high and 1 in the first cycle after release (IDLE). `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, `cnt`=0.
- Latency: a request accepted on edge E produces `rsp_valid` high in the cycle after edge E+`LATENCY`−1. With `LATENCY`=1, `rsp_valid` is seen the cycle after acceptance.
- Peak throughput: one request per `LATENCY` cycles, given `rsp_ready` held high.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, `rsp_rdata` and `rsp_fault` do not change and no request is accepted.
- Reset mid-operation:
  - In WAIT: the pending store is dropped with no write, and the FSM goes to IDLE.
  - In RESP: the store has already committed; the response is discarded.
- A store immediately followed by a load to the same address returns the new data, because the load's access edge is strictly later.

## Test plan
- Reset with `LATENCY`=1: sw 0xDEADBEEF to 0x10, then lw 0x10 → `rsp_rdata`=0xDEADBEEF, `rsp_fault`=0, each response one cycle after acceptance.
- Byte/half extension: lb 0x13 → 0xFFFFFFDE; lbu 0x13 → 0x000000DE; lh 0x12 → 0xFFFFDEAD; lhu 0x12 → 0x0000DEAD.
- Faults:
  - lw 0x11 → `rsp_fault`=1, rdata 0.
  - sh 0x21 → fault, and memory at 0x20..0x23 unchanged.
  - lw 0xFFC with `DEPTH_BYTES`=4096 → no fault; lw 0x1000 → fault.
  - `funct3`=011 → fault.
- `LATENCY`=3 with backpressure:
  - Accept at cycle 0 → `rsp_valid` at cycle 3.
  - Hold `rsp_ready`=0 for 4 cycles → outputs stable and `req_ready`=0.
  - Then raise `rsp_ready` together with `req_valid` → back-to-back acceptance in that cycle.
- Reset in WAIT (`LATENCY`=4): sw 0x11223344 to 0x40, assert `rst` 2 cycles after acceptance → `rsp_valid`=0, then lw 0x40 returns the old contents.
- Streaming with `LATENCY`=1 and `rsp_ready`=1: 8 alternating sw/lw requests → one response per cycle, each lw returning its preceding sw data.

Source files
------------

// File: rtl/lsu_data_mem.sv
// lsu_data_mem
//   Load/store data memory with valid/ready request and response handshakes,
//   a configurable access latency and fault reporting. Accepts RISC-V
//   funct3-encoded loads and stores. It applies byte lanes and sign or zero
//   extension to loads. Misaligned, out-of-range and illegal accesses are
//   rejected with rsp_fault instead of being executed.
//
// Parameters
//   XLEN        data and address width (at least 32)
//   DEPTH_BYTES byte capacity, power of two, >= 4
//   LATENCY     cycles from request acceptance to rsp_valid, >= 1
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   req_valid / req_ready  request handshake
//   req_we                 1 = store, 0 = load
//   req_funct3             000 b, 001 h, 010 w, 100 bu, 101 hu
//   req_addr, req_wdata    byte address and store data (low bytes used)
//   rsp_valid / rsp_ready  response handshake
//   rsp_rdata              extended load data; 0 for stores and faults
//   rsp_fault              access rejected
module lsu_data_mem #(
    parameter int XLEN        = 32,
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            accept, enter_resp;

    logic            l_we;
    logic [2:0]      l_f3;
    logic [XLEN-1:0] l_addr, l_wdata;

    logic            a_we;
    logic [2:0]      a_f3;
    logic [XLEN-1:0] a_addr, a_wdata;
    logic [31:0]     a_wd;
    logic [2:0]      a_size;
    logic            a_illegal, a_misalign, a_oor, a_fault;
    logic [XLEN:0]   a_last;
    logic [XLEN-1:0] a_rdata;
    logic [AW-1:0]   idx;
    logic [7:0]      b0, b1, b2, b3;

    logic [7:0]      mem [0:DEPTH_BYTES-1];

    // Handshake and next-state logic
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        req_ready  = !rst && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
        rsp_valid  = (state == S_RESP);
        accept     = req_valid && req_ready;
        case (state)
            S_WAIT: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx   = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            if (LATENCY == 1) begin
                state_nx   = S_RESP;
                enter_resp = 1'b1;
            end else begin
                state_nx = S_WAIT;
                cnt_nx   = CW'(LATENCY - 1);
            end
        end
    end

    // With LATENCY=1 the access edge is also the acceptance edge, so the
    // access uses the live request; after a WAIT it uses the latched copy.
    always_comb begin
        a_we    = (state == S_WAIT) ? l_we    : req_we;
        a_f3    = (state == S_WAIT) ? l_f3    : req_funct3;
        a_addr  = (state == S_WAIT) ? l_addr  : req_addr;
        a_wdata = (state == S_WAIT) ? l_wdata : req_wdata;
        a_wd    = 32'(a_wdata);
    end

    // Fault classification
    always_comb begin
        a_size    = 3'd1;
        a_illegal = 1'b0;
        case (a_f3)
            3'b000:         a_size = 3'd1;
            3'b001:         a_size = 3'd2;
            3'b010:         a_size = 3'd4;
            3'b100, 3'b101: begin
                a_size    = a_f3[0] ? 3'd2 : 3'd1;
                a_illegal = a_we;
            end
            default:        a_illegal = 1'b1;
        endcase
        a_misalign = ((a_size == 3'd2) && a_addr[0]) ||
                     ((a_size == 3'd4) && (a_addr[1:0] != 2'b00));
        // One extra bit so an address near the top of XLEN cannot wrap into range
        a_last     = {1'b0, a_addr} + (XLEN+1)'(a_size) - (XLEN+1)'(1);
        a_oor      = (a_last >= (XLEN+1)'(DEPTH_BYTES));
        a_fault    = a_illegal || a_misalign || a_oor;
    end

    // Load path: reads the array as it stands before the access edge
    always_comb begin
        idx     = a_addr[AW-1:0];
        b0      = mem[idx];
        b1      = mem[idx + AW'(1)];
        b2      = mem[idx + AW'(2)];
        b3      = mem[idx + AW'(3)];
        a_rdata = '0;
        if (!a_we && !a_fault) begin
            case (a_f3)
                3'b000:  a_rdata = {{(XLEN-8){b0[7]}}, b0};
                3'b001:  a_rdata = {{(XLEN-16){b1[7]}}, b1, b0};
                3'b010:  a_rdata = XLEN'({b3, b2, b1, b0});
                3'b100:  a_rdata = XLEN'(b0);
                3'b101:  a_rdata = XLEN'({b1, b0});
                default: a_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            l_we      <= 1'b0;
            l_f3      <= '0;
            l_addr    <= '0;
            l_wdata   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                l_we    <= req_we;
                l_f3    <= req_funct3;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
            end
            if (enter_resp) begin
                rsp_rdata <= a_rdata;
                rsp_fault <= a_fault;
            end
        end
    end

    // Storage is not reset; rst gates the write so a store pending in WAIT
    // is dropped when reset hits on its access edge.
    always_ff @(posedge clk) begin
        if (enter_resp && !rst && a_we && !a_fault) begin
            mem[idx] <= a_wd[7:0];
            if (a_size >= 3'd2) mem[idx + AW'(1)] <= a_wd[15:8];
            if (a_size == 3'd4) begin
                mem[idx + AW'(2)] <= a_wd[23:16];
                mem[idx + AW'(3)] <= a_wd[31:24];
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_mem.sv
module tb_lsu_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        rv [3];
    logic        rr [3];
    logic        rq [3];
    logic        sv [3];
    logic        ft [3];
    logic [31:0] rd [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        fault;
        int          acc;
        bit          chk_lat;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    lsu_data_mem #(.XLEN(32), .DEPTH_BYTES(4096), .LATENCY(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rq[0]), .req_we(we),
        .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .rsp_valid(sv[0]),
        .rsp_ready(rr[0]), .rsp_rdata(rd[0]), .rsp_fault(ft[0]));
    lsu_data_mem #(.XLEN(32), .DEPTH_BYTES(4096), .LATENCY(3)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rq[1]), .req_we(we),
        .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .rsp_valid(sv[1]),
        .rsp_ready(rr[1]), .rsp_rdata(rd[1]), .rsp_fault(ft[1]));
    lsu_data_mem #(.XLEN(32), .DEPTH_BYTES(4096), .LATENCY(4)) u2 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rq[2]), .req_we(we),
        .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .rsp_valid(sv[2]),
        .rsp_ready(rr[2]), .rsp_rdata(rd[2]), .rsp_fault(ft[2]));

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response scoreboard: every completed response handshake pops one entry
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst && sv[d] && rr[d]) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp dut%0d: got response %h, expected none", d, rd[d]);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_dut"}, 32'(d), 32'(e.dut));
                    chk({e.name, "_rdata"}, rd[d], e.rdata);
                    chk({e.name, "_fault"}, 32'(ft[d]), 32'(e.fault));
                    if (e.chk_lat)
                        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(lat_of(d) - 1));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the acceptance edge
    task automatic issue(input int d, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ef, input bit lat,
                         input bit push, input string nm,
                         output int waits, output int acc);
        we = w; f3 = f; addr = a; wdata = wd; rv[d] = 1'b1;
        waits = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (rq[d]) break;
            waits++;
            if (waits > 50) break;
        end
        if (waits > 50) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: req_ready low for %0d cycles, expected acceptance within 50", nm, waits);
        end else begin
            acc = cyc + 1;
            if (push) sb.push_back('{d, er, ef, acc, lat, nm});
        end
        @(posedge clk);
        #1;
        rv[d] = 1'b0;
    endtask

    task automatic drain(string nm);
        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
        chk({nm, "_drained"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int w, acc, n;
        logic [31:0] sd;

        tbl.push_back('{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, "sw_10"});
        tbl.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, "lw_10"});
        tbl.push_back('{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, "lb_13"});
        tbl.push_back('{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0, "lbu_13"});
        tbl.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, "lh_12"});
        tbl.push_back('{1'b0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 1'b0, "lhu_12"});
        tbl.push_back('{1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0, "lb_10"});
        tbl.push_back('{1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0, "lh_10"});
        tbl.push_back('{1'b0, 3'b010, 32'h11,  32'h0,        32'h0,        1'b1, "lw_11_misal"});
        tbl.push_back('{1'b1, 3'b010, 32'h20,  32'hA5A5A5A5, 32'h0,        1'b0, "sw_20"});
        tbl.push_back('{1'b1, 3'b001, 32'h21,  32'h00001234, 32'h0,        1'b1, "sh_21_misal"});
        tbl.push_back('{1'b1, 3'b100, 32'h20,  32'h0,        32'h0,        1'b1, "store_f3_100"});
        tbl.push_back('{1'b0, 3'b010, 32'h20,  32'h0,        32'hA5A5A5A5, 1'b0, "lw_20_intact"});
        tbl.push_back('{1'b1, 3'b000, 32'h12,  32'hFFFFFF77, 32'h0,        1'b0, "sb_12"});
        tbl.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDE77BEEF, 1'b0, "lw_10_after_sb"});
        tbl.push_back('{1'b1, 3'b010, 32'hFFC, 32'h01020304, 32'h0,        1'b0, "sw_ffc"});
        tbl.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0,        32'h01020304, 1'b0, "lw_ffc_top"});
        tbl.push_back('{1'b0, 3'b100, 32'hFFF, 32'h0,        32'h00000001, 1'b0, "lbu_fff"});
        tbl.push_back('{1'b0, 3'b001, 32'hFFE, 32'h0,        32'h00000102, 1'b0, "lh_ffe"});
        tbl.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,       32'h0,        1'b1, "lw_1000_oor"});
        tbl.push_back('{1'b0, 3'b000, 32'h1000, 32'h0,       32'h0,        1'b1, "lb_1000_oor"});
        tbl.push_back('{1'b0, 3'b001, 32'hFFF, 32'h0,        32'h0,        1'b1, "lh_fff_misal"});
        tbl.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1, "lw_wrap_oor"});
        tbl.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, "f3_011"});
        tbl.push_back('{1'b0, 3'b110, 32'h10,  32'h0,        32'h0,        1'b1, "f3_110"});
        tbl.push_back('{1'b1, 3'b111, 32'h10,  32'h0,        32'h0,        1'b1, "store_f3_111"});

        rst = 1'b1; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
        for (int d = 0; d < 3; d++) begin
            rv[d] = 1'b0;
            rr[d] = 1'b1;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_req_ready%0d", d), 32'(rq[d]), 32'd0);
            chk($sformatf("rst_rsp_valid%0d", d), 32'(sv[d]), 32'd0);
            chk($sformatf("rst_rdata%0d", d), rd[d], 32'd0);
            chk($sformatf("rst_fault%0d", d), 32'(ft[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("idle_req_ready%0d", d), 32'(rq[d]), 32'd1);
        @(posedge clk);
        #1;

        // Vector table on LATENCY=1
        for (int i = 0; i < tbl.size(); i++)
            issue(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                  tbl[i].rdata, tbl[i].fault, 1'b1, 1'b1, tbl[i].name, w, acc);
        drain("table");

        // Streaming sw/lw pairs, one request per cycle
        for (int i = 0; i < 8; i++) begin
            sd = 32'hA0000000 + 32'(i / 2) * 32'h01010101;
            if (i % 2 == 0)
                issue(0, 1'b1, 3'b010, 32'h100 + 32'(4 * (i / 2)), sd, 32'h0, 1'b0,
                      1'b1, 1'b1, $sformatf("stream_sw%0d", i), w, acc);
            else
                issue(0, 1'b0, 3'b010, 32'h100 + 32'(4 * (i / 2)), 32'h0, sd, 1'b0,
                      1'b1, 1'b1, $sformatf("stream_lw%0d", i), w, acc);
            chk($sformatf("stream_wait%0d", i), 32'(w), 32'd0);
        end
        drain("stream");

        // LATENCY=3 with backpressure and back-to-back acceptance
        issue(1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 1'b1, "l3_sw_30", w, acc);
        drain("l3_sw");
        rr[1] = 1'b0;
        issue(1, 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, "l3_lw_30", w, acc);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (sv[1]) break;
            n++;
        end
        chk("l3_first_valid_cycles", 32'(cyc - acc), 32'd2);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("l3_hold_valid%0d", k), 32'(sv[1]), 32'd1);
            chk($sformatf("l3_hold_rdata%0d", k), rd[1], 32'hCAFEF00D);
            chk($sformatf("l3_hold_fault%0d", k), 32'(ft[1]), 32'd0);
            chk($sformatf("l3_hold_req_ready%0d", k), 32'(rq[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        rr[1] = 1'b1;
        issue(1, 1'b0, 3'b101, 32'h32, 32'h0, 32'h0000CAFE, 1'b0, 1'b1, 1'b1, "l3_b2b_lhu_32", w, acc);
        chk("l3_b2b_wait", 32'(w), 32'd0);
        drain("l3_b2b");

        // LATENCY=4: reset while a store waits drops the store
        issue(2, 1'b1, 3'b010, 32'h40, 32'h55667788, 32'h0, 1'b0, 1'b1, 1'b1, "l4_sw_old", w, acc);
        drain("l4_sw_old");
        issue(2, 1'b1, 3'b010, 32'h40, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b0, "l4_sw_dropped", w, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("l4_rst_rsp_valid", 32'(sv[2]), 32'd0);
        chk("l4_rst_req_ready", 32'(rq[2]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("l4_post_rst_req_ready", 32'(rq[2]), 32'd1);
        chk("l4_post_rst_rsp_valid", 32'(sv[2]), 32'd0);
        @(posedge clk);
        #1;
        issue(2, 1'b0, 3'b010, 32'h40, 32'h0, 32'h55667788, 1'b0, 1'b1, 1'b1, "l4_lw_40_old", w, acc);
        drain("l4_lw");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
